// File: rtl/arena_datapath_if.sv
// -----------------------------------------------------------------------------
// arena_datapath_if
//   Bundles the control inputs and game-state outputs of arena_datapath.
//
//   Control (master -> slave):
//     start_game  one-cycle start/restart request
//     tick        one-cycle frame-step request
//     left/right/shoot  level inputs, sampled in the MOVE cycle
//   State (slave -> master):
//     user_x, enemy_x/enemy_y (packed per enemy), bullet_x/bullet_y/
//     bullet_valid (packed per slot), gun_cooldown, ship_health,
//     current_score, best_score, game_over, busy, dbg_state (FSM state)
//
//   Request semantics: start_game and tick are single-cycle strobes with no
//   backpressure. A strobe takes effect only on a cycle where busy is low and
//   the current state accepts it (start_game in IDLE/WAIT/OVER, tick in WAIT).
//   A strobe presented at any other time is dropped, never queued.
// -----------------------------------------------------------------------------
interface arena_datapath_if #(
  parameter int GRID_W      = 160,
  parameter int GRID_H      = 120,
  parameter int NUM_ENEMIES = 4,
  parameter int NUM_BULLETS = 4,
  parameter int SCORE_W     = 8
);
  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);

  logic                         start_game;
  logic                         tick;
  logic                         left;
  logic                         right;
  logic                         shoot;

  logic [X_W-1:0]               user_x;
  logic [NUM_ENEMIES*X_W-1:0]   enemy_x;
  logic [NUM_ENEMIES*Y_W-1:0]   enemy_y;
  logic [NUM_BULLETS*X_W-1:0]   bullet_x;
  logic [NUM_BULLETS*Y_W-1:0]   bullet_y;
  logic [NUM_BULLETS-1:0]       bullet_valid;
  logic [3:0]                   gun_cooldown;
  logic [3:0]                   ship_health;
  logic [SCORE_W-1:0]           current_score;
  logic [SCORE_W-1:0]           best_score;
  logic                         game_over;
  logic                         busy;
  logic [2:0]                   dbg_state;

  modport master (
    output start_game, tick, left, right, shoot,
    input  user_x, enemy_x, enemy_y, bullet_x, bullet_y, bullet_valid,
           gun_cooldown, ship_health, current_score, best_score,
           game_over, busy, dbg_state
  );

  modport slave (
    input  start_game, tick, left, right, shoot,
    output user_x, enemy_x, enemy_y, bullet_x, bullet_y, bullet_valid,
           gun_cooldown, ship_health, current_score, best_score,
           game_over, busy, dbg_state
  );
endinterface

// File: rtl/arena_datapath.sv
// -----------------------------------------------------------------------------
// arena_datapath
//   Game datapath for the space shooter: ship position, a pool of player
//   bullets, descending enemies, gun cooldown, health, current and best score.
//   A frame tick (accepted in WAIT) runs MOVE, one COLLIDE cycle per enemy,
//   then COMMIT; all outputs are registered and final when busy falls.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-low reset
//     bus    arena_datapath_if.slave (controls in, game state out)
//
//   Optional feature macro: DIFFICULTY_RAMP_EN
//     defined   : drop period = max(1, DROP_PERIOD - (current_score >> 3))
//     undefined : drop period = DROP_PERIOD
// -----------------------------------------------------------------------------
module arena_datapath #(
  parameter int GRID_W      = 160,
  parameter int GRID_H      = 120,
  parameter int NUM_ENEMIES = 4,
  parameter int NUM_BULLETS = 4,
  parameter int SHIP_Y      = 112,
  parameter int HIT_HALF    = 2,
  parameter int HEALTH_INIT = 4,
  parameter int COOLDOWN    = 8,
  parameter int DROP_PERIOD = 4,
  parameter int SCORE_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  arena_datapath_if.slave  bus
);

  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);
  localparam int E_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;

  localparam logic [X_W-1:0]     X_MAX      = X_W'(GRID_W - 1);
  localparam logic [X_W-1:0]     X_MID      = X_W'(GRID_W / 2);
  localparam logic [X_W-1:0]     X_ONE      = X_W'(1);
  localparam logic [X_W-1:0]     HIT_X      = X_W'(HIT_HALF);
  localparam logic [Y_W-1:0]     Y_ONE      = Y_W'(1);
  localparam logic [Y_W-1:0]     SHIP_ROW   = Y_W'(SHIP_Y);
  localparam logic [Y_W-1:0]     SPAWN_Y    = Y_W'(SHIP_Y - 1);
  localparam logic [3:0]         HEALTH_RST = 4'(HEALTH_INIT);
  localparam logic [3:0]         CD_LOAD    = 4'(COOLDOWN);
  localparam logic [3:0]         PERIOD_BASE = 4'(DROP_PERIOD);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [E_W-1:0]     E_LAST     = E_W'(NUM_ENEMIES - 1);
  localparam logic [E_W-1:0]     E_ONE      = E_W'(1);
  localparam logic [7:0]         LFSR_SEED  = 8'hA5;

  // Evenly spaced home columns, each centred in its share of the playfield.
  function automatic logic [X_W-1:0] enemy_home(input int i);
    return X_W'(i * (GRID_W / NUM_ENEMIES) + GRID_W / (2 * NUM_ENEMIES));
  endfunction

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_MOVE    = 3'd2,
    S_COLLIDE = 3'd3,
    S_COMMIT  = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [E_W-1:0]      e_q, e_d;
  logic [X_W-1:0]      user_x_q, user_x_d;
  logic [X_W-1:0]      ex_q [NUM_ENEMIES];
  logic [X_W-1:0]      ex_d [NUM_ENEMIES];
  logic [Y_W-1:0]      ey_q [NUM_ENEMIES];
  logic [Y_W-1:0]      ey_d [NUM_ENEMIES];
  logic [X_W-1:0]      bx_q [NUM_BULLETS];
  logic [X_W-1:0]      bx_d [NUM_BULLETS];
  logic [Y_W-1:0]      by_q [NUM_BULLETS];
  logic [Y_W-1:0]      by_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] bv_q, bv_d;
  logic [3:0]          cd_q, cd_d;
  logic [3:0]          health_q, health_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  best_q, best_d;
  logic [3:0]          drop_q, drop_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic                busy_q, busy_d;
  logic                over_q, over_d;

  // Respawn column and LFSR step; the LFSR only moves when an enemy respawns.
  logic [7:0]          lfsr_next;
  logic [X_W+7:0]      respawn_prod;
  logic [X_W-1:0]      respawn_x;
  logic [3:0]          period;

  assign lfsr_next    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign respawn_prod = (X_W+8)'(lfsr_q) * (X_W+8)'(GRID_W);
  assign respawn_x    = X_W'(respawn_prod >> 8);

`ifdef DIFFICULTY_RAMP_EN
  logic [SCORE_W-1:0] ramp;
  assign ramp   = score_q >> 3;
  assign period = (ramp >= SCORE_W'(DROP_PERIOD)) ? 4'd1 : (PERIOD_BASE - 4'(ramp));
`else
  assign period = PERIOD_BASE;
`endif

  logic           free_found;
  logic           shoot_ok;
  logic           hit_found;
  logic           breach;
  logic [X_W-1:0] dx;
  logic [X_W-1:0] ex_cur;
  logic [Y_W-1:0] ey_cur;

  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    user_x_d   = user_x_q;
    ex_d       = ex_q;
    ey_d       = ey_q;
    bx_d       = bx_q;
    by_d       = by_q;
    bv_d       = bv_q;
    cd_d       = cd_q;
    health_d   = health_q;
    score_d    = score_q;
    best_d     = best_q;
    drop_d     = drop_q;
    lfsr_d     = lfsr_q;
    free_found = 1'b0;
    shoot_ok   = 1'b0;
    hit_found  = 1'b0;
    breach     = 1'b0;
    dx         = '0;
    ex_cur     = ex_q[e_q];
    ey_cur     = ey_q[e_q];

    case (state_q)
      S_IDLE, S_WAIT, S_OVER: begin
        if (bus.start_game) begin
          // New game: everything except best score and LFSR returns home.
          state_d  = S_WAIT;
          e_d      = '0;
          user_x_d = X_MID;
          for (int i = 0; i < NUM_ENEMIES; i++) begin
            ex_d[i] = enemy_home(i);
            ey_d[i] = '0;
          end
          for (int b = 0; b < NUM_BULLETS; b++) begin
            bx_d[b] = '0;
            by_d[b] = '0;
          end
          bv_d     = '0;
          cd_d     = '0;
          health_d = HEALTH_RST;
          score_d  = '0;
          drop_d   = '0;
        end else if (state_q == S_WAIT && bus.tick) begin
          state_d = S_MOVE;
        end
      end

      S_MOVE: begin
        if (bus.right && !bus.left && user_x_q != X_MAX) begin
          user_x_d = user_x_q + X_ONE;
        end else if (bus.left && !bus.right && user_x_q != '0) begin
          user_x_d = user_x_q - X_ONE;
        end

        for (int b = 0; b < NUM_BULLETS; b++) begin
          if (bv_q[b]) begin
            if (by_q[b] == '0) bv_d[b] = 1'b0;
            else               by_d[b] = by_q[b] - Y_ONE;
          end
        end

        // A slot vacated by a bullet leaving the top this tick is reusable.
        shoot_ok = bus.shoot && (cd_q == 4'd0);
        for (int b = 0; b < NUM_BULLETS; b++) begin
          if (!free_found && !bv_d[b]) begin
            free_found = 1'b1;
            if (shoot_ok) begin
              bv_d[b] = 1'b1;
              bx_d[b] = user_x_q;
              by_d[b] = SPAWN_Y;
            end
          end
        end
        if (shoot_ok && free_found) cd_d = CD_LOAD;
        else if (cd_q != 4'd0)      cd_d = cd_q - 4'd1;

        // >= rather than == so a period shrinking below the count still drops.
        if (drop_q >= period - 4'd1) begin
          drop_d = 4'd0;
          for (int i = 0; i < NUM_ENEMIES; i++) ey_d[i] = ey_q[i] + Y_ONE;
        end else begin
          drop_d = drop_q + 4'd1;
        end

        state_d = S_COLLIDE;
        e_d     = '0;
      end

      S_COLLIDE: begin
        for (int b = 0; b < NUM_BULLETS; b++) begin
          dx = (bx_q[b] >= ex_cur) ? (bx_q[b] - ex_cur) : (ex_cur - bx_q[b]);
          if (!hit_found && bv_q[b] && dx <= HIT_X && by_q[b] <= ey_cur) begin
            hit_found = 1'b1;
            bv_d[b]   = 1'b0;
          end
        end
        breach = !hit_found && (ey_cur >= SHIP_ROW);

        if (hit_found && score_q != SCORE_MAX) score_d = score_q + SCORE_ONE;
        if (breach && health_q != 4'd0)       health_d = health_q - 4'd1;

        if (hit_found || breach) begin
          ey_d[e_q] = '0;
          ex_d[e_q] = respawn_x;
          lfsr_d    = lfsr_next;
        end

        if (e_q == E_LAST) state_d = S_COMMIT;
        else               e_d     = e_q + E_ONE;
      end

      S_COMMIT: begin
        if (health_q == 4'd0) begin
          state_d = S_OVER;
          if (score_q > best_q) best_d = score_q;
        end else begin
          state_d = S_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MOVE) || (state_d == S_COLLIDE) || (state_d == S_COMMIT);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      e_q      <= '0;
      user_x_q <= X_MID;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        ex_q[i] <= enemy_home(i);
        ey_q[i] <= '0;
      end
      for (int b = 0; b < NUM_BULLETS; b++) begin
        bx_q[b] <= '0;
        by_q[b] <= '0;
      end
      bv_q     <= '0;
      cd_q     <= '0;
      health_q <= HEALTH_RST;
      score_q  <= '0;
      best_q   <= '0;
      drop_q   <= '0;
      lfsr_q   <= LFSR_SEED;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      user_x_q <= user_x_d;
      ex_q     <= ex_d;
      ey_q     <= ey_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      bv_q     <= bv_d;
      cd_q     <= cd_d;
      health_q <= health_d;
      score_q  <= score_d;
      best_q   <= best_d;
      drop_q   <= drop_d;
      lfsr_q   <= lfsr_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
    end
  end

  logic [NUM_ENEMIES*X_W-1:0] enemy_x_pk;
  logic [NUM_ENEMIES*Y_W-1:0] enemy_y_pk;
  logic [NUM_BULLETS*X_W-1:0] bullet_x_pk;
  logic [NUM_BULLETS*Y_W-1:0] bullet_y_pk;

  always_comb begin
    enemy_x_pk  = '0;
    enemy_y_pk  = '0;
    bullet_x_pk = '0;
    bullet_y_pk = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      enemy_x_pk[i*X_W +: X_W] = ex_q[i];
      enemy_y_pk[i*Y_W +: Y_W] = ey_q[i];
    end
    for (int b = 0; b < NUM_BULLETS; b++) begin
      bullet_x_pk[b*X_W +: X_W] = bx_q[b];
      bullet_y_pk[b*Y_W +: Y_W] = by_q[b];
    end
  end

  assign bus.user_x        = user_x_q;
  assign bus.enemy_x       = enemy_x_pk;
  assign bus.enemy_y       = enemy_y_pk;
  assign bus.bullet_x      = bullet_x_pk;
  assign bus.bullet_y      = bullet_y_pk;
  assign bus.bullet_valid  = bv_q;
  assign bus.gun_cooldown  = cd_q;
  assign bus.ship_health   = health_q;
  assign bus.current_score = score_q;
  assign bus.best_score    = best_q;
  assign bus.game_over     = over_q;
  assign bus.busy          = busy_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_arena_datapath.sv
// -----------------------------------------------------------------------------
// tb_arena_datapath
//   Directed bench for arena_datapath with default parameters: reset values,
//   ship saturation, busy length, bullet spawning/cooldown, a scored hit with
//   LFSR respawn, enemy breaches to game over, restart, ignored requests and
//   asynchronous reset mid-sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arena_datapath;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int NE       = 4;
  localparam int SHIP_Y   = 112;
  localparam int DROP     = 4;
  localparam int RESPAWN0 = (165 * 160) / 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  arena_datapath_if bus();
  arena_datapath dut (.clk(clk), .reset(rst_n), .bus(bus));

  // scoreboard
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  task automatic expect_v(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed %0d but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  function automatic logic [15:0] enx(input int i);
    return 16'(bus.enemy_x[i*X_W +: X_W]);
  endfunction
  function automatic logic [15:0] eny(input int i);
    return 16'(bus.enemy_y[i*Y_W +: Y_W]);
  endfunction
  function automatic logic [15:0] bux(input int i);
    return 16'(bus.bullet_x[i*X_W +: X_W]);
  endfunction
  function automatic logic [15:0] buy(input int i);
    return 16'(bus.bullet_y[i*Y_W +: Y_W]);
  endfunction

  // driver tasks
  task automatic do_start();
    @(negedge clk) bus.start_game = 1'b1;
    @(negedge clk) bus.start_game = 1'b0;
  endtask

  // One tick pulse; returns the number of cycles busy was high. With
  // mid_start set, a start_game pulse is thrown in during the first busy cycle.
  task automatic do_tick(input logic l, input logic r, input logic s,
                         input bit mid_start, output int busy_cyc);
    @(negedge clk);
    bus.left  = l;
    bus.right = r;
    bus.shoot = s;
    bus.tick  = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    busy_cyc = 0;
    while (bus.busy === 1'b1 && busy_cyc < 40) begin
      busy_cyc++;
      bus.start_game = mid_start && (busy_cyc == 1);
      @(negedge clk);
    end
    bus.start_game = 1'b0;
    if (busy_cyc >= 40) begin
      n_cmp++;
      n_bad++;
      $error("FAIL busy_timeout: busy=%0b after %0d cycles, required low", bus.busy, busy_cyc);
    end
    bus.left  = 1'b0;
    bus.right = 1'b0;
    bus.shoot = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int ux;
  int hit_n, b1, b2;

  initial begin
    bus.start_game = 1'b0;
    bus.tick       = 1'b0;
    bus.left       = 1'b0;
    bus.right      = 1'b0;
    bus.shoot      = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- reset values
    expect_v(16'd0);   chk("rst_state", 16'(bus.dbg_state));
    expect_v(16'd80);  chk("rst_user_x", 16'(bus.user_x));
    for (int i = 0; i < NE; i++) begin
      expect_v(16'(i * 40 + 20)); chk("rst_enemy_x", enx(i));
      expect_v(16'd0);            chk("rst_enemy_y", eny(i));
    end
    expect_v(16'd0); chk("rst_bullet_valid", 16'(bus.bullet_valid));
    expect_v(16'd0); chk("rst_cooldown", 16'(bus.gun_cooldown));
    expect_v(16'd4); chk("rst_health", 16'(bus.ship_health));
    expect_v(16'd0); chk("rst_score", 16'(bus.current_score));
    expect_v(16'd0); chk("rst_best", 16'(bus.best_score));
    expect_v(16'd0); chk("rst_game_over", 16'(bus.game_over));
    expect_v(16'd0); chk("rst_busy", 16'(bus.busy));

    // ---- tick in IDLE is ignored
    expect_v(16'd0);
    do_tick(1'b0, 1'b1, 1'b0, 1'b0, cyc);
    chk("idle_tick_busy", 16'(cyc));
    expect_v(16'd80); chk("idle_tick_user_x", 16'(bus.user_x));

    // ---- game 1: hold right for 100 ticks; start_game during busy ignored
    do_start();
    expect_v(16'd1); chk("start_state_wait", 16'(bus.dbg_state));
    ux = 80;
    for (int t = 1; t <= 100; t++) begin
      ux = (ux < 159) ? ux + 1 : 159;
      expect_v(16'd6);
      expect_v(16'(ux));
      do_tick(1'b0, 1'b1, 1'b0, (t == 50), cyc);
      chk("busy_cycles", 16'(cyc));
      chk("right_user_x", 16'(bus.user_x));
    end
    expect_v(16'(100 / DROP)); chk("drop_enemy_y", eny(1));

    // ---- game 2: hold shoot for 20 ticks
    do_start();
    for (int t = 1; t <= 20; t++) begin
      expect_v(16'((1 << ((t - 1) / 9 + 1)) - 1));
      expect_v(16'(8 - ((t - 1) % 9)));
      expect_v(16'(SHIP_Y - 1 - (t - 1)));
      do_tick(1'b0, 1'b0, 1'b1, 1'b0, cyc);
      chk("shoot_valid", 16'(bus.bullet_valid));
      chk("shoot_cooldown", 16'(bus.gun_cooldown));
      chk("shoot_bullet0_y", buy(0));
      if (t == 10) begin
        expect_v(16'd80);  chk("spawn1_x", bux(1));
        expect_v(16'd111); chk("spawn1_y", buy(1));
      end
    end

    // ---- game 3: move to x=21, fire once, hit enemy 0, then breaches
    do_start();
    for (int t = 1; t <= 59; t++) do_tick(1'b1, 1'b0, 1'b0, 1'b0, cyc);
    expect_v(16'd21);          chk("left_user_x", 16'(bus.user_x));
    expect_v(16'(59 / DROP));  chk("pre_fire_enemy0_y", eny(0));
    expect_v(16'd20);          chk("pre_fire_enemy0_x", enx(0));
    expect_v(16'd1); expect_v(16'd21); expect_v(16'(SHIP_Y - 1));
    do_tick(1'b0, 1'b0, 1'b1, 1'b0, cyc);
    chk("fire_valid", 16'(bus.bullet_valid));
    chk("fire_x", bux(0));
    chk("fire_y", buy(0));

    hit_n = 0; b1 = 0; b2 = 0;
    for (int n = 61; n < 400 && hit_n == 0; n++)
      if ((SHIP_Y - 1 - (n - 60)) <= n / DROP) hit_n = n;
    for (int n = 1; n < 1000 && b1 == 0; n++)
      if (n / DROP >= SHIP_Y) b1 = n;
    for (int n = hit_n + 1; n < 2000 && b2 == 0; n++)
      if (n / DROP - hit_n / DROP >= SHIP_Y) b2 = n;

    for (int n = 61; n <= b2; n++) begin
      expect_v(16'((n >= hit_n) ? 1 : 0));
      expect_v(16'(4 - ((n >= b1) ? 3 : 0) - ((n >= b2) ? 1 : 0)));
      expect_v(16'((n >= b2) ? 1 : 0));
      do_tick(1'b0, 1'b0, 1'b0, 1'b0, cyc);
      chk("g3_score", 16'(bus.current_score));
      chk("g3_health", 16'(bus.ship_health));
      chk("g3_game_over", 16'(bus.game_over));
      if (n == hit_n) begin
        expect_v(16'(RESPAWN0)); chk("hit_respawn_x", enx(0));
        expect_v(16'd0);         chk("hit_respawn_y", eny(0));
        expect_v(16'd0);         chk("hit_bullet_gone", 16'(bus.bullet_valid));
      end
      if (n == b1) begin
        for (int i = 1; i < NE; i++) begin
          expect_v(16'd0); chk("breach_respawn_y", eny(i));
        end
        expect_v(16'(b1 / DROP - hit_n / DROP)); chk("enemy0_y_at_breach", eny(0));
      end
      if (n == b2) begin
        expect_v(16'd1); chk("best_after_over", 16'(bus.best_score));
        expect_v(16'd5); chk("state_over", 16'(bus.dbg_state));
      end
    end

    // ---- tick in OVER is ignored
    expect_v(16'd0); expect_v(16'd1);
    do_tick(1'b0, 1'b1, 1'b0, 1'b0, cyc);
    chk("over_tick_busy", 16'(cyc));
    chk("over_hold", 16'(bus.game_over));

    // ---- restart keeps best score
    do_start();
    expect_v(16'd0);  chk("restart_game_over", 16'(bus.game_over));
    expect_v(16'd1);  chk("restart_best", 16'(bus.best_score));
    expect_v(16'd0);  chk("restart_score", 16'(bus.current_score));
    expect_v(16'd4);  chk("restart_health", 16'(bus.ship_health));
    expect_v(16'd80); chk("restart_user_x", 16'(bus.user_x));
    expect_v(16'd20); chk("restart_enemy0_x", enx(0));
    expect_v(16'd0);  chk("restart_enemy0_y", eny(0));
    expect_v(16'd0);  chk("restart_bullets", 16'(bus.bullet_valid));

    // ---- asynchronous reset in the middle of an update
    @(negedge clk);
    bus.right = 1'b1;
    bus.tick  = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    expect_v(16'd1); chk("busy_before_areset", 16'(bus.busy));
    #2 rst_n = 1'b0;
    #1;
    expect_v(16'd0);  chk("areset_busy", 16'(bus.busy));
    expect_v(16'd0);  chk("areset_state", 16'(bus.dbg_state));
    expect_v(16'd0);  chk("areset_best", 16'(bus.best_score));
    expect_v(16'd80); chk("areset_user_x", 16'(bus.user_x));
    @(negedge clk);
    rst_n     = 1'b1;
    bus.right = 1'b0;
    @(negedge clk);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
